// File: rtl/load_use_scoreboard_pkg.sv
`default_nettype none
// ============================================================================
// Module      : hazard_pkg
// Description : Shared types and constants for the load-use hazard unit.
//               Holds the scoreboard entry layout, the latency ceiling and the
//               output-decode state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package hazard_pkg;

  // Deepest load latency the scoreboard is built to track.
  localparam int LOAD_LAT_MAX = 4;

  // Register-address width assumed by the packed entry type below.
  localparam int LD_ADDR_W = 5;

  // One scoreboard slot: an in-flight load and its destination register.
  typedef struct packed {
    logic                 valid;
    logic [LD_ADDR_W-1:0] rd;
  } ld_entry_t;

  // Output decode, listed in rising priority order.
  typedef enum logic [1:0] {
    HZ_RUN    = 2'd0,
    HZ_BUBBLE = 2'd1,
    HZ_FREEZE = 2'd2
  } hz_state_e;

endpackage : hazard_pkg
`default_nettype wire

// File: rtl/load_track_queue.sv
`default_nettype none
// ============================================================================
// Module      : load_track_queue
// Description : Shift-register scoreboard of in-flight loads. Entry 0 is the
//               youngest; each enabled cycle every entry moves one slot older
//               and the oldest drops out. When the enable is low the whole
//               queue holds.
// Ports       : clk_i, rst_n_i   - clock, asynchronous active-low reset
//               shiftEn_i        - advance the queue this cycle
//               pushValid_i      - a load issues into entry 0
//               pushRd_i         - destination register of that load
//               valid_o / rd_o   - per-entry contents for the comparators
// Revision    : 1.0 - initial release
// ============================================================================
module load_track_queue #(
  parameter int ADDR_W   = 5,
  parameter int LOAD_LAT = 1
) (
  input  logic                             clk_i,
  input  logic                             rst_n_i,
  input  logic                             shiftEn_i,
  input  logic                             pushValid_i,
  input  logic [ADDR_W-1:0]                pushRd_i,
  output logic [LOAD_LAT-1:0]              valid_o,
  output logic [LOAD_LAT-1:0][ADDR_W-1:0]  rd_o
);

  logic [LOAD_LAT-1:0]             r_valid;
  logic [LOAD_LAT-1:0][ADDR_W-1:0] r_rd;

  // x0 is never tracked, even if a caller pushes it, so it can never match.
  logic w_pushValid;
  assign w_pushValid = pushValid_i & (pushRd_i != '0);

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_valid[0] <= 1'b0;
      r_rd[0]    <= '0;
    end else if (shiftEn_i) begin
      r_valid[0] <= w_pushValid;
      r_rd[0]    <= pushRd_i;
    end
  end

  for (genvar k = 1; k < LOAD_LAT; k++) begin : g_shift
    always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
        r_valid[k] <= 1'b0;
        r_rd[k]    <= '0;
      end else if (shiftEn_i) begin
        r_valid[k] <= r_valid[k-1];
        r_rd[k]    <= r_rd[k-1];
      end
    end
  end

  assign valid_o = r_valid;
  assign rd_o    = r_rd;

endmodule : load_track_queue
`default_nettype wire

// File: rtl/load_use_scoreboard.sv
`default_nettype none
// ============================================================================
// Module      : load_use_scoreboard
// Description : Load-use hazard unit beside the ID stage. Compares the ID
//               sources against every in-flight load, decides RUN / BUBBLE /
//               FREEZE for the front end and counts load-use bubble cycles
//               in a saturating counter.
// Ports       : clk_i, rst_n_i            - clock, async active-low reset
//               id_valid_i                - ID holds a real instruction
//               rs1/rs2_addr_i, _used_i   - ID sources and their use flags
//               rd_addr_i, memread_i      - ID destination, ID is a load
//               flush_i                   - ID instruction squashed
//               mem_stall_i               - data memory busy, freeze
//               pc_write_o, stall_o       - PC update enable, hold IF/ID
//               noop_o                    - bubble into ID/EX
//               stall_cnt_o               - saturating bubble-cycle count
// Revision    : 1.0 - initial release
// ============================================================================
module load_use_scoreboard
  import hazard_pkg::*;
#(
  parameter int ADDR_W   = 5,
  parameter int LOAD_LAT = 1,
  parameter int CNT_W    = 16
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              id_valid_i,
  input  logic [ADDR_W-1:0] rs1_addr_i,
  input  logic [ADDR_W-1:0] rs2_addr_i,
  input  logic              rs1_used_i,
  input  logic              rs2_used_i,
  input  logic [ADDR_W-1:0] rd_addr_i,
  input  logic              memread_i,
  input  logic              flush_i,
  input  logic              mem_stall_i,
  output logic              pc_write_o,
  output logic              stall_o,
  output logic              noop_o,
  output logic [CNT_W-1:0]  stall_cnt_o
);

  localparam logic [CNT_W-1:0] c_cntOne = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] c_cntMax = {CNT_W{1'b1}};

  logic [LOAD_LAT-1:0]             w_qValid;
  logic [LOAD_LAT-1:0][ADDR_W-1:0] w_qRd;
  logic                            w_match;
  logic                            w_hazard;
  logic                            w_issueLd;
  hz_state_e                       w_state;
  logic [CNT_W-1:0]                r_stallCnt;

  // The queue holds through a freeze, which is what stretches the hazard
  // window by one cycle per frozen cycle.
  load_track_queue #(
    .ADDR_W   (ADDR_W),
    .LOAD_LAT (LOAD_LAT)
  ) u_queue (
    .clk_i       (clk_i),
    .rst_n_i     (rst_n_i),
    .shiftEn_i   (~mem_stall_i),
    .pushValid_i (w_issueLd),
    .pushRd_i    (rd_addr_i),
    .valid_o     (w_qValid),
    .rd_o        (w_qRd)
  );

  // Unused sources are masked so I/U-type immediates that land in a source
  // field never cause a false stall.
  always_comb begin
    w_match = 1'b0;
    for (int k = 0; k < LOAD_LAT; k++) begin
      if (w_qValid[k] &&
          ((rs1_used_i && (w_qRd[k] == rs1_addr_i)) ||
           (rs2_used_i && (w_qRd[k] == rs2_addr_i)))) begin
        w_match = 1'b1;
      end
    end
  end

  assign w_hazard  = id_valid_i & ~flush_i & w_match;
  assign w_issueLd = id_valid_i & memread_i & (rd_addr_i != '0) &
                     ~w_hazard & ~flush_i & ~mem_stall_i;

  // Freeze outranks the bubble; the hazard is simply re-evaluated once the
  // freeze lifts because the queue has not moved.
  always_comb begin
    if (mem_stall_i) begin
      w_state = HZ_FREEZE;
    end else if (w_hazard) begin
      w_state = HZ_BUBBLE;
    end else begin
      w_state = HZ_RUN;
    end
  end

  always_comb begin
    pc_write_o = 1'b1;
    stall_o    = 1'b0;
    noop_o     = 1'b0;
    case (w_state)
      HZ_FREEZE: begin
        pc_write_o = 1'b0;
        stall_o    = 1'b1;
        noop_o     = 1'b0;
      end
      HZ_BUBBLE: begin
        pc_write_o = 1'b0;
        stall_o    = 1'b1;
        noop_o     = 1'b1;
      end
      default: begin
        pc_write_o = 1'b1;
        stall_o    = 1'b0;
        noop_o     = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_stallCnt <= '0;
    end else if ((w_state == HZ_BUBBLE) && (r_stallCnt != c_cntMax)) begin
      r_stallCnt <= r_stallCnt + c_cntOne;
    end
  end

  assign stall_cnt_o = r_stallCnt;

endmodule : load_use_scoreboard
`default_nettype wire

// File: tb/tb_load_use_scoreboard.sv
`default_nettype none
// ============================================================================
// Module      : tb_load_use_scoreboard
// Description : Directed self-checking bench. Three instances share one set
//               of ID-stage inputs: d1 (LOAD_LAT=1, CNT_W=4), d2 (LOAD_LAT=2)
//               and d3 (LOAD_LAT=3); each scenario checks the instance it
//               targets. Outputs are packed as {pc_write, stall, noop}.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_load_use_scoreboard;

  localparam logic [2:0] RUN = 3'b100;
  localparam logic [2:0] BUB = 3'b011;
  localparam logic [2:0] FRZ = 3'b010;

  logic       clk = 1'b0;
  logic       rstN;
  logic       idValid, rs1Used, rs2Used, memread, flush, memStall;
  logic [4:0] rs1, rs2, rd;

  logic        pcw1, stl1, nop1;
  logic [3:0]  cnt1;
  logic        pcw2, stl2, nop2;
  logic [15:0] cnt2;
  logic        pcw3, stl3, nop3;
  logic [15:0] cnt3;

  int nCompared   = 0;
  int nMismatched = 0;

  always #5 clk = ~clk;

  load_use_scoreboard #(.ADDR_W(5), .LOAD_LAT(1), .CNT_W(4)) d1 (
    .clk_i(clk), .rst_n_i(rstN), .id_valid_i(idValid),
    .rs1_addr_i(rs1), .rs2_addr_i(rs2), .rs1_used_i(rs1Used), .rs2_used_i(rs2Used),
    .rd_addr_i(rd), .memread_i(memread), .flush_i(flush), .mem_stall_i(memStall),
    .pc_write_o(pcw1), .stall_o(stl1), .noop_o(nop1), .stall_cnt_o(cnt1));

  load_use_scoreboard #(.ADDR_W(5), .LOAD_LAT(2), .CNT_W(16)) d2 (
    .clk_i(clk), .rst_n_i(rstN), .id_valid_i(idValid),
    .rs1_addr_i(rs1), .rs2_addr_i(rs2), .rs1_used_i(rs1Used), .rs2_used_i(rs2Used),
    .rd_addr_i(rd), .memread_i(memread), .flush_i(flush), .mem_stall_i(memStall),
    .pc_write_o(pcw2), .stall_o(stl2), .noop_o(nop2), .stall_cnt_o(cnt2));

  load_use_scoreboard #(.ADDR_W(5), .LOAD_LAT(3), .CNT_W(16)) d3 (
    .clk_i(clk), .rst_n_i(rstN), .id_valid_i(idValid),
    .rs1_addr_i(rs1), .rs2_addr_i(rs2), .rs1_used_i(rs1Used), .rs2_used_i(rs2Used),
    .rd_addr_i(rd), .memread_i(memread), .flush_i(flush), .mem_stall_i(memStall),
    .pc_write_o(pcw3), .stall_o(stl3), .noop_o(nop3), .stall_cnt_o(cnt3));

  // ---------------- stimulus helpers (drive only) ----------------
  task automatic idle();
    idValid = 0; rs1 = 0; rs2 = 0; rs1Used = 0; rs2Used = 0;
    rd = 0; memread = 0; flush = 0; memStall = 0;
  endtask

  task automatic setId(input logic [4:0] s1, input logic u1, input logic [4:0] s2,
                       input logic u2, input logic [4:0] d, input logic ld);
    idValid = 1; rs1 = s1; rs1Used = u1; rs2 = s2; rs2Used = u2;
    rd = d; memread = ld; flush = 0;
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    rstN = 0;
    idle();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rstN = 1;
    tick();
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rstN = 0;
    idle();
    #3;
    nCompared++;
    if ({pcw1, stl1, nop1} !== RUN) begin
      nMismatched++; $display("FAIL reset_out_d1: got %b expected %b", {pcw1, stl1, nop1}, RUN);
    end
    nCompared++;
    if ({pcw3, stl3, nop3} !== RUN) begin
      nMismatched++; $display("FAIL reset_out_d3: got %b expected %b", {pcw3, stl3, nop3}, RUN);
    end
    nCompared++;
    if (cnt1 !== 4'd0 || cnt2 !== 16'd0 || cnt3 !== 16'd0) begin
      nMismatched++; $display("FAIL reset_cnt: got %0d/%0d/%0d expected 0/0/0", cnt1, cnt2, cnt3);
    end
    doReset();
  endtask

  task automatic test_lat1_single();
    doReset();
    setId(5'd2, 1, 5'd0, 0, 5'd5, 1);          // lw x5
    #1;
    nCompared++;
    if ({pcw1, stl1, nop1} !== RUN) begin
      nMismatched++; $display("FAIL lat1_load_cycle: got %b expected %b", {pcw1, stl1, nop1}, RUN);
    end
    tick();
    setId(5'd5, 1, 5'd1, 1, 5'd6, 0);          // add x6,x5,x1
    #1;
    nCompared++;
    if ({pcw1, stl1, nop1} !== BUB) begin
      nMismatched++; $display("FAIL lat1_bubble: got %b expected %b", {pcw1, stl1, nop1}, BUB);
    end
    tick();
    #1;
    nCompared++;
    if ({pcw1, stl1, nop1} !== RUN) begin
      nMismatched++; $display("FAIL lat1_issue: got %b expected %b", {pcw1, stl1, nop1}, RUN);
    end
    nCompared++;
    if (cnt1 !== 4'd1) begin
      nMismatched++; $display("FAIL lat1_cnt: got %0d expected 1", cnt1);
    end
    idle();
  endtask

  task automatic test_lat3_store();
    logic [2:0] expSeq [4];
    expSeq = '{BUB, BUB, BUB, RUN};
    doReset();
    setId(5'd2, 1, 5'd0, 0, 5'd7, 1);          // lw x7
    tick();
    setId(5'd7, 1, 5'd9, 1, 5'd0, 0);          // sw x9, 0(x7)
    for (int i = 0; i < 4; i++) begin
      #1;
      nCompared++;
      if ({pcw3, stl3, nop3} !== expSeq[i]) begin
        nMismatched++;
        $display("FAIL lat3_cycle%0d: got %b expected %b", i + 1, {pcw3, stl3, nop3}, expSeq[i]);
      end
      tick();
    end
    nCompared++;
    if (cnt3 !== 16'd3) begin
      nMismatched++; $display("FAIL lat3_cnt: got %0d expected 3", cnt3);
    end
    idle();
  endtask

  task automatic test_no_false_stall();
    doReset();
    setId(5'd2, 1, 5'd0, 0, 5'd0, 1);          // lw x0
    tick();
    setId(5'd0, 1, 5'd0, 1, 5'd1, 0);          // add x1,x0,x0
    #1;
    nCompared++;
    if ({pcw1, stl1, nop1} !== RUN || {pcw3, stl3, nop3} !== RUN) begin
      nMismatched++;
      $display("FAIL x0_nostall: got %b/%b expected %b", {pcw1, stl1, nop1}, {pcw3, stl3, nop3}, RUN);
    end
    tick();
    setId(5'd2, 1, 5'd0, 0, 5'd8, 1);          // lw x8
    tick();
    setId(5'd2, 1, 5'd8, 0, 5'd9, 0);          // addi x9,x2,8 (rs2 field = 8, unused)
    #1;
    nCompared++;
    if ({pcw1, stl1, nop1} !== RUN || {pcw3, stl3, nop3} !== RUN) begin
      nMismatched++;
      $display("FAIL unused_rs2: got %b/%b expected %b", {pcw1, stl1, nop1}, {pcw3, stl3, nop3}, RUN);
    end
    // Same encoding with rs2 actually read must stall.
    rs2Used = 1;
    #1;
    nCompared++;
    if ({pcw1, stl1, nop1} !== BUB) begin
      nMismatched++; $display("FAIL used_rs2: got %b expected %b", {pcw1, stl1, nop1}, BUB);
    end
    rs2Used = 0;
    tick();
    #1;
    nCompared++;
    if (cnt1 !== 4'd0) begin
      nMismatched++; $display("FAIL nostall_cnt: got %0d expected 0", cnt1);
    end
    idle();
  endtask

  task automatic test_freeze();
    logic [2:0] expSeq [5];
    logic       stallSeq [5];
    expSeq   = '{FRZ, FRZ, BUB, BUB, RUN};
    stallSeq = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    doReset();
    setId(5'd2, 1, 5'd0, 0, 5'd4, 1);          // lw x4
    tick();
    setId(5'd4, 1, 5'd3, 1, 5'd10, 0);         // dependent on x4
    for (int i = 0; i < 5; i++) begin
      memStall = stallSeq[i];
      #1;
      nCompared++;
      if ({pcw2, stl2, nop2} !== expSeq[i]) begin
        nMismatched++;
        $display("FAIL freeze_cycle%0d: got %b expected %b", i + 1, {pcw2, stl2, nop2}, expSeq[i]);
      end
      tick();
    end
    nCompared++;
    if (cnt2 !== 16'd2) begin
      nMismatched++; $display("FAIL freeze_cnt: got %0d expected 2", cnt2);
    end
    idle();
  endtask

  task automatic test_flush();
    logic [2:0] expSeq [3];
    expSeq = '{BUB, BUB, RUN};
    doReset();
    setId(5'd2, 1, 5'd0, 0, 5'd3, 1);          // lw x3
    tick();
    setId(5'd3, 1, 5'd0, 0, 5'd11, 0);
    flush = 1;                                  // squashed dependent
    #1;
    nCompared++;
    if ({pcw3, stl3, nop3} !== RUN) begin
      nMismatched++; $display("FAIL flush_cycle: got %b expected %b", {pcw3, stl3, nop3}, RUN);
    end
    tick();
    setId(5'd3, 1, 5'd0, 0, 5'd12, 0);         // new dependent, not flushed
    for (int i = 0; i < 3; i++) begin
      #1;
      nCompared++;
      if ({pcw3, stl3, nop3} !== expSeq[i]) begin
        nMismatched++;
        $display("FAIL flush_after%0d: got %b expected %b", i + 1, {pcw3, stl3, nop3}, expSeq[i]);
      end
      tick();
    end
    nCompared++;
    if (cnt3 !== 16'd2) begin
      nMismatched++; $display("FAIL flush_cnt: got %0d expected 2", cnt3);
    end
    idle();
  endtask

  task automatic test_back_to_back();
    logic [2:0] expSeq [4];
    expSeq = '{BUB, BUB, BUB, RUN};
    doReset();
    setId(5'd2, 1, 5'd0, 0, 5'd5, 1);          // lw x5
    tick();
    setId(5'd2, 1, 5'd0, 0, 5'd5, 1);          // lw x5 again
    #1;
    nCompared++;
    if ({pcw3, stl3, nop3} !== RUN) begin
      nMismatched++; $display("FAIL b2b_second_load: got %b expected %b", {pcw3, stl3, nop3}, RUN);
    end
    tick();
    setId(5'd5, 1, 5'd0, 0, 5'd6, 0);          // dependent on youngest x5
    for (int i = 0; i < 4; i++) begin
      #1;
      nCompared++;
      if ({pcw3, stl3, nop3} !== expSeq[i]) begin
        nMismatched++;
        $display("FAIL b2b_cycle%0d: got %b expected %b", i + 1, {pcw3, stl3, nop3}, expSeq[i]);
      end
      tick();
    end
    nCompared++;
    if (cnt3 !== 16'd3) begin
      nMismatched++; $display("FAIL b2b_cnt: got %0d expected 3", cnt3);
    end
    idle();
  endtask

  task automatic test_saturate_and_reset();
    doReset();
    for (int p = 1; p <= 20; p++) begin
      setId(5'd2, 1, 5'd0, 0, 5'd5, 1);        // lw x5
      tick();
      setId(5'd5, 1, 5'd1, 1, 5'd6, 0);        // dependent: one bubble
      tick();
      tick();                                   // dependent issues
      if (p == 14) begin
        nCompared++;
        if (cnt1 !== 4'd14) begin
          nMismatched++; $display("FAIL sat_pair14: got %0d expected 14", cnt1);
        end
      end
      if (p == 16) begin
        nCompared++;
        if (cnt1 !== 4'd15) begin
          nMismatched++; $display("FAIL sat_pair16: got %0d expected 15", cnt1);
        end
      end
    end
    nCompared++;
    if (cnt1 !== 4'd15) begin
      nMismatched++; $display("FAIL sat_final: got %0d expected 15", cnt1);
    end
    // Reset in the middle of a bubble.
    setId(5'd2, 1, 5'd0, 0, 5'd5, 1);
    tick();
    setId(5'd5, 1, 5'd1, 1, 5'd6, 0);
    #1;
    nCompared++;
    if ({pcw1, stl1, nop1} !== BUB) begin
      nMismatched++; $display("FAIL pre_reset_bubble: got %b expected %b", {pcw1, stl1, nop1}, BUB);
    end
    rstN = 0;
    #1;
    nCompared++;
    if ({pcw1, stl1, nop1} !== RUN) begin
      nMismatched++; $display("FAIL midreset_out: got %b expected %b", {pcw1, stl1, nop1}, RUN);
    end
    nCompared++;
    if (cnt1 !== 4'd0) begin
      nMismatched++; $display("FAIL midreset_cnt: got %0d expected 0", cnt1);
    end
    @(negedge clk);
    rstN = 1;
    tick();
    #1;
    nCompared++;                                // pending x5 entry was dropped
    if ({pcw1, stl1, nop1} !== RUN || cnt1 !== 4'd0) begin
      nMismatched++;
      $display("FAIL post_reset: got %b cnt %0d expected %b cnt 0", {pcw1, stl1, nop1}, cnt1, RUN);
    end
    idle();
  endtask

  initial begin
    test_reset();
    test_lat1_single();
    test_lat3_store();
    test_no_false_stall();
    test_freeze();
    test_flush();
    test_back_to_back();
    test_saturate_and_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule : tb_load_use_scoreboard
`default_nettype wire
